i2c_target_regs: RTL
====================

# i2c_target_regs

I2C target (responder) exposing a bank of 8-bit configuration registers to an external I2C controller, the counterpart of the on-FPGA I2C controller that drives the HDMI transmitter. It decodes START/STOP, matches a 7-bit address, supports pointer-then-data writes and pointer-based sequential reads, and issues a write strobe to the fabric for each accepted data byte. Pins are open-drain: the block only ever pulls SDA low and never drives SCL. No clock stretching.

## Interface
- SLAVE_ADDR, 7'h3C, 7-bit target address.
- NUM_REGS, 16, implemented registers, 1..256; addresses >= NUM_REGS are unimplemented.
- FILTER_LEN, 3, consecutive identical samples required to accept a new SCL/SDA level.

- clk  in  1  system clock; must be >= 16x SCL frequency.
- reset  in  1  synchronous, active-low.
- scl_in  in  1  raw SCL pin level (async).
- sda_in  in  1  raw SDA pin level (async).
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- busy  out  1  high from address-matched START until STOP, NACK or address mismatch.
- wr_strobe  out  1  one-clk pulse per data byte written to an implemented register.
- wr_addr  out  8  register address of the last write.
- wr_data  out  8  data of the last write.
- regs_flat  out  NUM_REGS*8  register contents, reg n at bits [8n+7:8n].

## Operation
- Input conditioning: 2-FF synchronizer per line, then a glitch filter; the filtered level changes only after FILTER_LEN equal samples. Edges are detected on filtered signals.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Both apply in any state and take priority.
  - START (including repeated START) -> ADDR, bit counter cleared, sda_oe 0.
  - STOP -> IDLE, sda_oe 0, busy 0.
- Bit timing:
  - Bits are sampled on SCL rising edges, MSB first.
  - sda_oe changes only on SCL falling edges, except on START, STOP or reset.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK.
  - ADDR: shift 8 bits. On match with SLAVE_ADDR: busy 1, assert sda_oe on the next falling edge -> ADDR_ACK. On mismatch: -> IDLE, no drive, until the next START.
  - ADDR_ACK: release on the following falling edge.
    - R/W = 0 -> PTR.
    - R/W = 1 -> RDATA; load shifter from regs[ptr] at that same falling edge and drive bit 7 (sda_oe = ~bit).
  - PTR: 8 bits -> ptr, ACK always -> WDATA.
  - WDATA: 8 bits, ACK always.
    - If ptr < NUM_REGS: write regs[ptr], pulse wr_strobe, set wr_addr and wr_data.
    - Otherwise the byte is discarded without a strobe.
    - Then ptr += 1 (8-bit wrap, 0xFF -> 0x00).
  - RDATA: shift out 8 bits, release SDA after the 8th falling edge -> RDATA_MACK.
  - RDATA_MACK: sample SDA on the rising edge.
    - Low (ACK): ptr += 1, load next byte at the falling edge -> RDATA.
    - High (NACK): -> IDLE, busy 0.
- Read of ptr >= NUM_REGS returns 8'hFF.
- ptr persists across transactions; reset only by reset.

## Timing
- Reset values: sda_oe 0, busy 0, wr_strobe 0, wr_addr 0, wr_data 0, all registers 0, ptr 0, state IDLE.
- Pin-to-detect latency: 2 + FILTER_LEN clk.
- sda_oe update: 1 clk after the filtered SCL falling edge is detected.
- Write path: wr_strobe is high exactly 1 clk, registered, 1 clk after the rising edge of the 8th data bit is detected. regs_flat, wr_addr and wr_data update in the same cycle as wr_strobe.
- reset low mid-transfer: every output returns to its reset value on the next clk edge. After release, the block ignores the bus until a new START.
- START and STOP are never detected together; if SCL is low, SDA edges are data transitions only.

## Test plan
- Write: START, 0x78 (0x3C,W), 0x03, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; wr_strobe twice; regs[3]=0xA5, regs[4]=0x5A; wr_addr ends at 0x04; busy falls at STOP.
- Read with repeated START: START, 0x78, 0x03, Sr, 0x79, read, ACK, read, NACK, STOP -> bytes 0xA5 then 0x5A; sda_oe 0 during NACK bit and after.
- Address mismatch: START, 0x7A, 0x00, 0xFF, STOP -> sda_oe never asserted; no wr_strobe; busy stays 0; registers unchanged.
- Bounds and wrap:
  - Write ptr 0x0F with data 0x11, 0x22 -> regs[15]=0x11; second byte ACKed, no strobe.
  - Write ptr 0xFF with data 0x33 -> ptr wraps to 0x00.
  - A subsequent read returns regs[0], read at ptr 0x10 returns 0xFF.
- Glitch: 2-clk low pulse on SDA while SCL high (FILTER_LEN=3) -> no START/STOP detected, state unchanged; 2-clk SCL pulse adds no bit.
- Reset mid-transfer: assert reset during ADDR_ACK with sda_oe=1 -> sda_oe 0 next clk; after release, data bits without START are ignored; next full write succeeds.

Source files
------------

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing a bank of 8-bit registers
module i2c_target_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic                  busy,
  output logic                  wr_strobe,
  output logic [7:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic [NUM_REGS*8-1:0] regs_flat
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK
  } state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]    s0, s1, filt, filt_q;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge clk) begin
    s0 <= {sda_in, scl_in};
    s1 <= s0;
  end

  // Filters track the synchronized pins while in reset so release creates no edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt   <= s1;
      filt_q <= s1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s1[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= s1[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, scl_p, sda_f, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_f     = filt[0];
  assign scl_p     = filt_q[0];
  assign sda_f     = filt[1];
  assign sda_p     = filt_q[1];
  assign scl_rise  = scl_f & ~scl_p;
  assign scl_fall  = ~scl_f & scl_p;
  assign start_det = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;

  state_t     state, state_n;
  logic [3:0] bit_cnt, cnt_n;
  logic [7:0] shift, shift_n, ptr, ptr_n;
  logic       rw, rw_n, oe_n, busy_n, do_write;
  logic [7:0] wbyte, ptr_rd, rd_byte;
  logic [7:0] regs [NUM_REGS];

  assign wbyte = {shift[6:0], sda_f};

  // A read after a master ACK fetches the byte at the already-incremented pointer.
  always_comb begin
    ptr_rd  = (state == RDATA_MACK) ? ptr + 8'd1 : ptr;
    rd_byte = 8'hFF;
    if (int'(ptr_rd) < NUM_REGS) rd_byte = regs[ptr_rd[AW-1:0]];
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i*8 +: 8] = regs[i];
  end

  always_comb begin
    state_n  = state;
    cnt_n    = bit_cnt;
    shift_n  = shift;
    ptr_n    = ptr;
    rw_n     = rw;
    oe_n     = sda_oe;
    busy_n   = busy;
    do_write = 1'b0;
    if (start_det) begin
      state_n = ADDR;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
    end else if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_n = wbyte;
            cnt_n   = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (state == ADDR) begin
                if (shift[6:0] == SLAVE_ADDR) begin
                  busy_n = 1'b1;
                  rw_n   = sda_f;
                end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                end
              end else if (state == WDATA) begin
                do_write = (int'(ptr) < NUM_REGS);
                ptr_n    = ptr + 8'd1;
              end
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            oe_n = 1'b1;
            case (state)
              ADDR:    state_n = ADDR_ACK;
              PTR: begin
                state_n = PTR_ACK;
                ptr_n   = shift;
              end
              default: state_n = WDATA_ACK;
            endcase
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_n = 4'd0;
            if (rw) begin
              state_n = RDATA;
              shift_n = rd_byte;
              oe_n    = ~rd_byte[7];
            end else begin
              state_n = PTR;
              oe_n    = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_n = WDATA;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n = RDATA_MACK;
              cnt_n   = 4'd0;
              oe_n    = 1'b0;
            end else begin
              shift_n = {shift[6:0], 1'b0};
              oe_n    = ~shift[6];
            end
          end
        end
        RDATA_MACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end else begin
              cnt_n = 4'd1;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            state_n = RDATA;
            cnt_n   = 4'd0;
            ptr_n   = ptr + 8'd1;
            shift_n = rd_byte;
            oe_n    = ~rd_byte[7];
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'd0;
      ptr       <= 8'd0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
    end else begin
      state     <= state_n;
      bit_cnt   <= cnt_n;
      shift     <= shift_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      sda_oe    <= oe_n;
      busy      <= busy_n;
      wr_strobe <= do_write;
      if (do_write) begin
        regs[ptr[AW-1:0]] <= wbyte;
        wr_addr           <= ptr;
        wr_data           <= wbyte;
      end
    end
  end

endmodule
